riscv_fetch_unit: RTL



---
 rtl/riscv_pkg.sv | 12 +
 rtl/riscv_fetch_queue.sv | 73 +++++++
 rtl/riscv_fetch_unit.sv | 90 +++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants for the Riscv151 fetch front end.
`default_nettype none

package riscv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_2000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam int unsigned PC_STEP          = 4;

endpackage

`default_nettype wire

// File: rtl/riscv_fetch_queue.sv
// fetch_queue: synchronous FIFO of {pc, inst}; flush wins, pop-on-empty and push-on-full are ignored.
`default_nettype none

module fetch_queue
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [XLEN-1:0]            push_pc,
  input  logic [XLEN-1:0]            push_inst,
  input  logic                       pop,
  output logic [XLEN-1:0]            head_pc,
  output logic [XLEN-1:0]            head_inst,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTRW = $clog2(DEPTH);

  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [XLEN-1:0] mem_inst [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (PTRW+1)'(DEPTH));
  assign do_push   = push && !full && !flush;
  assign do_pop    = pop && !empty && !flush;
  assign head_pc   = mem_pc[rd_ptr];
  assign head_inst = mem_inst[rd_ptr];

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_inst[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem_pc[wr_ptr]   <= push_pc;
        mem_inst[wr_ptr] <= push_inst;
        wr_ptr           <= wr_ptr + PTRW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTRW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTRW+1)'(1);
        2'b01:   count <= count - (PTRW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: decoupled fetch stage owning fetch PC, in-flight/kill tracking and issue credit.
`default_nettype none

module riscv_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic [XLEN-1:0]        icache_addr,
  output logic                   icache_re,
  input  logic [XLEN-1:0]        icache_dout,
  input  logic                   stall,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [XLEN-1:0]        inst,
  output logic [XLEN-1:0]        inst_pc,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic            killed;
  logic [CW:0]     credit_used;
  logic            accept;
  logic            capture;
  logic            push;
  logic            pop;
  logic            empty;
  logic            full;

  // A credit is consumed by every queued entry and by the request in flight.
  assign credit_used = {1'b0, occupancy} + {{CW{1'b0}}, inflight};
  assign icache_re   = !reset && (redirect_valid || (credit_used < (CW+1)'(DEPTH)));
  assign icache_addr = redirect_valid ? redirect_pc : fetch_pc;
  assign accept      = icache_re && !stall;
  assign capture     = inflight && !stall;
  assign push        = capture && !killed && !redirect_valid;
  assign inst_valid  = !empty && !redirect_valid;
  assign pop         = inst_valid && inst_ready;

  // Any acceptance while a request is in flight coincides with its capture,
  // so at most one request is ever outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      killed   <= 1'b0;
    end else begin
      inflight <= accept || (inflight && stall);
      killed   <= (redirect_valid ? inflight : killed) && stall;
      if (accept) begin
        req_pc   <= icache_addr;
        fetch_pc <= icache_addr + XLEN'(PC_STEP);
      end else begin
        fetch_pc <= icache_addr;
      end
    end
  end

  fetch_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_pc   (req_pc),
    .push_inst (icache_dout),
    .pop       (pop),
    .head_pc   (inst_pc),
    .head_inst (inst),
    .empty     (empty),
    .full      (full),
    .count     (occupancy)
  );

endmodule

`default_nettype wire
